// File: rtl/instr_exec_reader_pkg.sv
// Instruction-register types shared by the stimulus writer, the exec reader
// and the scoreboard's reference model.
package instr_exec_reader_pkg;

  localparam int ADDR_W = 5;
  localparam int OPER_W = 32;
  // Must be at least 2*OPER_W so a full product and INT_MIN/-1 both fit.
  localparam int RES_W  = 64;

  typedef logic        [ADDR_W-1:0] address_t;
  typedef logic        [ADDR_W:0]   count_t;
  typedef logic signed [OPER_W-1:0] operand_t;
  typedef logic signed [RES_W-1:0]  result_t;

  // 4-bit encoding leaves 8..15 undefined; those execute as errors.
  typedef enum logic [3:0] {
    OP_ZERO  = 4'd0,
    OP_PASSA = 4'd1,
    OP_PASSB = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_MULT  = 4'd5,
    OP_DIV   = 4'd6,
    OP_MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t  opcode;
    operand_t operand_a;
    operand_t operand_b;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    OUTPUT = 3'd3,
    DONE   = 3'd4
  } exec_state_t;

  function automatic result_t sext(input operand_t v);
    return {{(RES_W-OPER_W){v[OPER_W-1]}}, v};
  endfunction

endpackage

// File: rtl/instr_exec_reader_alu.sv
// Combinational executor for one instruction word; also used by the
// scoreboard reference model, so it carries no state.
module instr_alu
  import instr_exec_reader_pkg::*;
(
  input  instruction_t instr,
  output result_t      result,
  output logic         err
);

  result_t a, b;

  always_comb begin
    a      = sext(instr.operand_a);
    b      = sext(instr.operand_b);
    result = '0;
    err    = 1'b0;
    case (instr.opcode)
      OP_ZERO:  result = '0;
      OP_PASSA: result = a;
      OP_PASSB: result = b;
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_MULT:  result = a * b;
      OP_DIV: begin
        if (b == '0) err = 1'b1;
        else         result = a / b;
      end
      OP_MOD: begin
        if (b == '0) err = 1'b1;
        else         result = a % b;
      end
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_exec_reader.sv
// Walks a run of instruction-register addresses, executes each word and
// streams one result per instruction on a valid/ready port.
module instr_exec_reader
  import instr_exec_reader_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  address_t     first_addr,
  input  count_t       count,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         res_valid,
  input  logic         res_ready,
  output result_t      res_data,
  output address_t     res_addr,
  output logic         res_err,
  output logic         busy,
  output logic         done
);

  exec_state_t  state_q, state_d;
  address_t     rp_q, rp_d;
  count_t       rem_q, rem_d;
  instruction_t instr_q, instr_d;
  result_t      res_data_q, res_data_d;
  address_t     res_addr_q, res_addr_d;
  logic         res_valid_q, res_valid_d;
  logic         res_err_q, res_err_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  result_t alu_res;
  logic    alu_err;

  instr_alu u_alu (
    .instr  (instr_q),
    .result (alu_res),
    .err    (alu_err)
  );

  always_comb begin
    state_d     = state_q;
    rp_d        = rp_q;
    rem_d       = rem_q;
    instr_d     = instr_q;
    res_data_d  = res_data_q;
    res_addr_d  = res_addr_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            rp_d    = first_addr;
            rem_d   = count;
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      FETCH: begin
        instr_d = instruction_word;
        state_d = EXEC;
      end
      EXEC: begin
        res_data_d  = alu_res;
        res_err_d   = alu_err;
        res_addr_d  = rp_q;
        res_valid_d = 1'b1;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          rp_d        = rp_q + address_t'(1);
          rem_d       = rem_q - count_t'(1);
          state_d     = (rem_q == count_t'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        // Pulse lands in the cycle after DONE, as the FSM returns to IDLE.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rp_q        <= '0;
      rem_q       <= '0;
      instr_q     <= '0;
      res_data_q  <= '0;
      res_addr_q  <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rp_q        <= rp_d;
      rem_q       <= rem_d;
      instr_q     <= instr_d;
      res_data_q  <= res_data_d;
      res_addr_q  <= res_addr_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign read_pointer = rp_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_addr     = res_addr_q;
  assign res_err      = res_err_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_instr_exec_reader.sv
// Scoreboard bench: expected results are queued at start, a negedge monitor
// pops and compares on every handshake.
module tb_instr_exec_reader;
  import instr_exec_reader_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         res_ready = 1'b0;
  address_t     first_addr = '0;
  count_t       count = '0;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         res_valid, res_err, busy, done;
  result_t      res_data;
  address_t     res_addr;

  instruction_t mem [0:DEPTH-1];

  typedef struct {
    int     addr;
    longint data;
    logic   err;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_neg = -1;
  int rdy_mode = 0;

  instr_exec_reader dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .first_addr       (first_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_addr         (res_addr),
    .res_err          (res_err),
    .busy             (busy),
    .done             (done)
  );

  assign instruction_word = mem[read_pointer];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = 1'($urandom % 2);
    endcase
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference semantics straight from the opcode table, in 64-bit integers.
  function automatic void model(input instruction_t w, output longint d, output logic e);
    longint a, b;
    a = longint'(w.operand_a);
    b = longint'(w.operand_b);
    d = 0;
    e = 1'b0;
    case (int'(w.opcode))
      0: d = 0;
      1: d = a;
      2: d = b;
      3: d = a + b;
      4: d = a - b;
      5: d = a * b;
      6: if (b == 0) e = 1'b1; else d = a / b;
      7: if (b == 0) e = 1'b1; else d = a % b;
      default: e = 1'b1;
    endcase
  endfunction

  function automatic instruction_t mk(input int op, input int a, input int b);
    instruction_t w;
    w.opcode    = opcode_t'(op[3:0]);
    w.operand_a = a;
    w.operand_b = b;
    return w;
  endfunction

  function automatic int rand_oper();
    case ($urandom % 6)
      0: return int'($urandom);
      1: return 0;
      2: return -1;
      3: return 1;
      4: return int'(32'h8000_0000);
      default: return int'($urandom_range(0, 20)) - 10;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && res_valid && res_ready) begin
      hs_neg = cyc;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got addr %0d, expected no result", res_addr);
      end else begin
        e = q.pop_front();
        chk("res_addr", longint'(res_addr), longint'(e.addr));
        chk("res_data", longint'(res_data), e.data);
        chk("res_err", longint'(res_err), longint'(e.err));
      end
    end
  end

  task automatic start_run(input int first, input int cnt);
    longint d;
    logic   e;
    int     a;
    for (int i = 0; i < cnt; i++) begin
      a = (first + i) % DEPTH;
      model(mem[a], d, e);
      q.push_back('{a, d, e});
    end
    @(posedge clk); #1;
    first_addr = address_t'(first);
    count      = count_t'(cnt);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (res_valid) return;
    end
    chk("res_valid_timeout", 0, 1);
  endtask

  task automatic wait_done(input int cnt, output int n);
    int gaps = 0;
    bit got = 0;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (done) begin
        got = 1;
        break;
      end
      if (!busy) gaps++;
    end
    chk("done_seen", longint'(got), 1);
    chk("busy_gaps", gaps, 0);
    chk("queue_empty", q.size(), 0);
    q.delete();
    if (cnt == 0) chk("done_latency_cnt0", n, 2);
    else          chk("done_after_hs", cyc - hs_neg, 2);
    chk("busy_at_done", longint'(busy), 0);
    @(negedge clk);
    chk("done_one_cycle", longint'(done), 0);
  endtask

  initial begin
    int n;
    int dn;
    for (int i = 0; i < DEPTH; i++) mem[i] = mk(0, 0, 0);

    #2 reset = 1'b1;
    #2;
    chk("rst_read_pointer", longint'(read_pointer), 0);
    chk("rst_res_valid", longint'(res_valid), 0);
    chk("rst_res_data", longint'(res_data), 0);
    chk("rst_res_addr", longint'(res_addr), 0);
    chk("rst_res_err", longint'(res_err), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Basic run with first-result latency
    mem[0] = mk(3, 5, 7);
    mem[1] = mk(4, 5, 7);
    mem[2] = mk(5, -3, 4);
    rdy_mode = 1;
    start_run(0, 3);
    wait_valid(n);
    chk("first_latency", n, 3);
    wait_done(3, n);

    // Wrap-around, full-throughput timing
    mem[30] = mk(1, 111, 0);
    mem[31] = mk(2, 0, -222);
    mem[0]  = mk(3, 1000, -1);
    mem[1]  = mk(5, int'(32'h8000_0000), int'(32'h8000_0000));
    start_run(30, 4);
    wait_done(4, n);
    chk("wrap_run_cycles", n, 3 * 4 + 2);

    // Backpressure holds the pending result stable
    mem[5] = mk(3, 1, 1);
    rdy_mode = 0;
    start_run(5, 1);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", longint'(res_valid), 1);
      chk("bp_data", longint'(res_data), 2);
      chk("bp_addr", longint'(res_addr), 5);
      chk("bp_read_pointer", longint'(read_pointer), 5);
      @(negedge clk);
    end
    rdy_mode = 1;
    @(negedge clk);
    rdy_mode = 0;
    @(negedge clk);
    chk("bp_valid_dropped", longint'(res_valid), 0);
    wait_done(1, n);

    // Divide by zero then a normal MOD
    mem[10] = mk(6, 10, 0);
    mem[11] = mk(7, -7, 2);
    mem[12] = mk(13, 4, 4);
    mem[13] = mk(6, int'(32'h8000_0000), -1);
    rdy_mode = 1;
    start_run(10, 4);
    wait_done(4, n);

    // Empty run
    start_run(7, 0);
    wait_done(0, n);

    // Reset two cycles into OUTPUT aborts the run
    mem[0] = mk(3, 5, 7);
    mem[1] = mk(4, 5, 7);
    mem[2] = mk(5, -3, 4);
    rdy_mode = 0;
    start_run(0, 3);
    wait_valid(n);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_read_pointer", longint'(read_pointer), 0);
    chk("abort_res_valid", longint'(res_valid), 0);
    chk("abort_res_data", longint'(res_data), 0);
    chk("abort_res_addr", longint'(res_addr), 0);
    chk("abort_res_err", longint'(res_err), 0);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("abort_no_done", dn, 0);
    rdy_mode = 1;
    start_run(0, 3);
    wait_done(3, n);

    // Randomized runs with random backpressure
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] = mk(int'($urandom_range(0, 11)), rand_oper(), rand_oper());
      rdy_mode = 2;
      start_run(int'($urandom % DEPTH), int'($urandom_range(0, DEPTH)));
      wait_done(int'(count), n);
    end
    rdy_mode = 0;

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_exec_reader.md
Name: instr_exec_reader

Overview:
- Read-side consumer of the instruction register. Walks a range of instruction-register addresses through its read port.
- Executes each fetched instruction (opcode, operand_a, operand_b) and presents one result per instruction on a valid/ready stream.
- Sits between the instruction register's read port and a result checker or scoreboard. It is the counterpart of the stimulus writer that loads the register.

Parameters:
- ADDR_W, 5, read-pointer width; register depth is 2**ADDR_W.
- OPER_W, 32, signed operand width.
- RES_W, 64, signed result width; must be at least 2*OPER_W.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- first_addr  in  ADDR_W  first address of the run.
- count  in  ADDR_W+1  number of instructions in the run, 0..2**ADDR_W.
- read_pointer  out  ADDR_W  address driven to the register read port.
- instruction_word  in  instruction_t  combinational read data for read_pointer.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  RES_W  signed result.
- res_addr  out  ADDR_W  address the result came from.
- res_err  out  1  divide or modulo by zero for this result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset values (asynchronous assert): state IDLE; read_pointer, res_data, res_addr = 0; res_valid, res_err, busy, done = 0; remaining counter = 0.
- IDLE:
  - start=1 and count!=0: latch read_pointer<=first_addr and remaining<=count, go to FETCH.
  - start=1 and count==0: go to DONE (no results).
  - start=0: stay.
- FETCH: capture instruction_word into an internal register; go to EXEC.
- EXEC: compute the result into res_data; res_addr<=read_pointer; go to OUTPUT with res_valid=1.
- OUTPUT:
  - Hold res_valid, res_data, res_addr, res_err stable until res_ready=1.
  - On handshake: res_valid<=0; read_pointer<=read_pointer+1, wrapping 2**ADDR_W-1 to 0; remaining<=remaining-1.
  - Then go to DONE if remaining was 1, else FETCH.
- DONE: done=1 for exactly one cycle; go to IDLE.
- start is ignored whenever state!=IDLE.
- Latency: start to first res_valid is 3 cycles. Steady-state throughput is 3 cycles per result with res_ready held high.
- Arithmetic: operands are sign-extended to RES_W and the result is signed.
  - ZERO: 0
  - PASSA: a
  - PASSB: b
  - ADD: a+b
  - SUB: a-b
  - MULT: full a*b
  - DIV: a/b, truncating toward zero
  - MOD: a%b, sign of a
- DIV or MOD with b==0: res_data=0, res_err=1. res_err=0 for all other cases.
- Undefined opcode encoding: res_data=0, res_err=1.
- res_ready high while res_valid is low has no effect.
- Reset asserted mid-run aborts immediately: no done pulse; the pending result is discarded.

Decomposition:
- Shared package (the instruction-register package): opcode_t, operand_t, address_t, instruction_t already live there.
- Add to that package:
  - result_t, signed RES_W.
  - exec_state_t enum {IDLE, FETCH, EXEC, OUTPUT, DONE}.
- One sub-module, instr_alu: purely combinational, instruction_t in, result_t plus err out. It is shared with the scoreboard's reference model.

Test Plan:
- Reset, then start with first_addr=0, count=3. Register holds ADD(5,7), SUB(5,7), MULT(-3,4) at addresses 0..2.
  - Results must be 12, -2, -12 at res_addr 0, 1, 2.
  - done pulses one cycle after the third handshake.
- Wrap-around: first_addr=30, count=4, res_ready=1. res_addr sequence must be 30, 31, 0, 1, with busy high throughout.
- Backpressure: res_ready=0 for 5 cycles while an ADD(1,1) result is pending.
  - res_valid, res_data=2, res_addr stay stable.
  - read_pointer does not advance.
  - One cycle of res_ready completes the handshake.
- Divide by zero: DIV(10,0) gives res_data=0, res_err=1. The next instruction, MOD(-7,2), gives -1 with res_err=0.
- start with count=0: no res_valid; done pulses 2 cycles after start; busy high for 1 cycle only.
- Reset asserted 2 cycles into OUTPUT: all outputs return to 0 immediately, state is IDLE, no done pulse. A fresh start then runs normally.
